// File: rtl/fifo_lvl.sv
// ---------------------------------------------------------------------------
// fifo_lvl : synchronous first-word fall-through FIFO with level reporting,
//            threshold flags and optional sticky error flags.
//
// Optional feature macro: FIFO_LVL_ERR_FLAGS_EN
//   defined   -> overflow/underflow are sticky flags cleared by clr_err
//   undefined -> overflow/underflow tied to 0, clr_err ignored
//
// Parameters
//   FIFO_WIDTH     data bits per entry
//   FIFO_DEPTH     entry count (power of two, >= 2)
//   AFULL_THRESH   almost_full asserts when level >= this value
//   AEMPTY_THRESH  almost_empty asserts when level <= this value
//
// Ports
//   clk           rising-edge clock for all state
//   reset_n       asynchronous active-low reset
//   push/data_in  write request and data
//   pop           read request
//   flush         synchronous clear of pointers (storage untouched)
//   clr_err       clears sticky error flags
//   ack           one-cycle pulse the cycle after each accepted push
//   data_out      head entry (combinational from the read pointer)
//   full/empty    occupancy flags
//   almost_full/almost_empty  threshold flags derived from level
//   level         current entry count, 0..FIFO_DEPTH
//   overflow/underflow        sticky error flags
// ---------------------------------------------------------------------------
module fifo_lvl #(
    parameter int FIFO_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 4,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          push,
    input  logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          pop,
    input  logic                          flush,
    input  logic                          clr_err,
    output logic                          ack,
    output logic [FIFO_WIDTH-1:0]         data_out,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    localparam logic [PW-1:0] AFULL_LVL  = PW'(AFULL_THRESH);
    localparam logic [PW-1:0] AEMPTY_LVL = PW'(AEMPTY_THRESH);

    logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  push_ok;
    logic                  pop_ok;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    // without a separate counter: equal pointers mean empty, equal index bits
    // with opposite wrap bits mean full.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // Flush overrides both requests. A pop on an empty FIFO is never accepted,
    // so push+pop on empty only writes; push on full is dropped even if a pop
    // frees a slot in the same cycle.
    assign push_ok = push && !full  && !flush;
    assign pop_ok  = pop  && !empty && !flush;

    // Modulo-2*DEPTH subtraction falls out of the PW-bit arithmetic.
    assign level        = wr_ptr - rd_ptr;
    assign almost_full  = (level >= AFULL_LVL);
    assign almost_empty = (level <= AEMPTY_LVL);

    assign data_out = mem[rd_ptr[AW-1:0]];

    // NOTE: all sequential state uses non-blocking assignments so every flop
    // samples pre-edge values and the order of statements does not matter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ack    <= 1'b0;
        end else begin
            ack <= push_ok;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + 1'b1;
                if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // NOTE: storage is reset along with the pointers so data_out reads 0 out
    // of reset and a mid-operation reset leaves no stale data visible; this
    // forces the array into flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= data_in;
        end
    end

`ifdef FIFO_LVL_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // A new error in the same cycle as clr_err wins, so no event is lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (push && full && !flush) overflow_q <= 1'b1;
            else if (clr_err)           overflow_q <= 1'b0;

            if (pop && empty && !flush) underflow_q <= 1'b1;
            else if (clr_err)           underflow_q <= 1'b0;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    logic unused_clr_err;

    assign unused_clr_err = clr_err;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_lvl.sv
// ---------------------------------------------------------------------------
// tb_fifo_lvl : directed self-checking bench for fifo_lvl (8 x 4, defaults).
// Error-flag expectations follow FIFO_LVL_ERR_FLAGS_EN when defined.
// ---------------------------------------------------------------------------
module tb_fifo_lvl;

`ifdef FIFO_LVL_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       clk;
    logic       reset_n;
    logic       push;
    logic [7:0] data_in;
    logic       pop;
    logic       flush;
    logic       clr_err;
    logic       ack;
    logic [7:0] data_out;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [2:0] level;
    logic       overflow;
    logic       underflow;

    int checks;
    int errors;

    fifo_lvl #(.FIFO_WIDTH(8), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .flush        (flush),
        .clr_err      (clr_err),
        .ack          (ack),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .level        (level),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        push = 1'b0; pop = 1'b0; flush = 1'b0; clr_err = 1'b0; data_in = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (empty !== 1'b1)        begin errors++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0)         begin errors++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (level !== 3'd0)        begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL reset_aempty: got %b want 1", almost_empty); end
        checks++; if (almost_full !== 1'b0)  begin errors++; $display("FAIL reset_afull: got %b want 0", almost_full); end
        checks++; if (data_out !== 8'h00)    begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
        checks++; if (ack !== 1'b0)          begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
        checks++; if (overflow !== 1'b0)     begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
        checks++; if (underflow !== 1'b0)    begin errors++; $display("FAIL reset_udf: got %b want 0", underflow); end
        reset_n = 1'b1;
    endtask

    task automatic test_fill();
        logic [7:0] vals [4];
        logic       af_exp [4];
        logic       ae_exp [4];
        vals   = '{8'h11, 8'h22, 8'h33, 8'h44};
        af_exp = '{1'b0, 1'b0, 1'b1, 1'b1};
        ae_exp = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; data_in = vals[i];
            step();
            checks++; if (ack !== 1'b1)               begin errors++; $display("FAIL fill_ack[%0d]: got %b want 1", i, ack); end
            checks++; if (level !== 3'(i + 1))        begin errors++; $display("FAIL fill_level[%0d]: got %0d want %0d", i, level, i + 1); end
            checks++; if (almost_full !== af_exp[i])  begin errors++; $display("FAIL fill_afull[%0d]: got %b want %b", i, almost_full, af_exp[i]); end
            checks++; if (almost_empty !== ae_exp[i]) begin errors++; $display("FAIL fill_aempty[%0d]: got %b want %b", i, almost_empty, ae_exp[i]); end
            checks++; if (full !== (i == 3))          begin errors++; $display("FAIL fill_full[%0d]: got %b want %b", i, full, (i == 3)); end
            checks++; if (data_out !== 8'h11)         begin errors++; $display("FAIL fill_head[%0d]: got %h want 11", i, data_out); end
        end
        push = 1'b0;
        step();
        checks++; if (ack !== 1'b0)   begin errors++; $display("FAIL fill_ack_idle: got %b want 0", ack); end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL fill_level_idle: got %0d want 4", level); end
    endtask

    task automatic test_full_push_pop();
        push = 1'b1; pop = 1'b1; data_in = 8'h55;
        step();
        push = 1'b0; pop = 1'b0;
        checks++; if (ack !== 1'b0)        begin errors++; $display("FAIL fpp_ack: got %b want 0", ack); end
        checks++; if (level !== 3'd3)      begin errors++; $display("FAIL fpp_level: got %0d want 3", level); end
        checks++; if (full !== 1'b0)       begin errors++; $display("FAIL fpp_full: got %b want 0", full); end
        checks++; if (data_out !== 8'h22)  begin errors++; $display("FAIL fpp_head: got %h want 22", data_out); end
        checks++; if (overflow !== ERR_EN) begin errors++; $display("FAIL fpp_ovf: got %b want %b", overflow, ERR_EN); end
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        checks++; if (overflow !== 1'b0)   begin errors++; $display("FAIL fpp_ovf_clr: got %b want 0", overflow); end
        checks++; if (level !== 3'd3)      begin errors++; $display("FAIL fpp_level_clr: got %0d want 3", level); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] q [$];
        // Drop 0x22 to reach level 2 with 0x33, 0x44 queued.
        pop = 1'b1;
        step();
        pop = 1'b0;
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL b2b_start_level: got %0d want 2", level); end
        q = '{8'h33, 8'h44};
        for (int i = 0; i < 10; i++) begin
            push = 1'b1; pop = 1'b1; data_in = 8'hA0 + 8'(i);
            #1;
            checks++; if (data_out !== q[0]) begin errors++; $display("FAIL b2b_head[%0d]: got %h want %h", i, data_out, q[0]); end
            step();
            void'(q.pop_front());
            q.push_back(8'hA0 + 8'(i));
            checks++; if (level !== 3'd2) begin errors++; $display("FAIL b2b_level[%0d]: got %0d want 2", i, level); end
            checks++; if (ack !== 1'b1)   begin errors++; $display("FAIL b2b_ack[%0d]: got %b want 1", i, ack); end
        end
        push = 1'b0; pop = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (data_out !== q[0]) begin errors++; $display("FAIL b2b_drain[%0d]: got %h want %h", i, data_out, q[0]); end
            step();
            void'(q.pop_front());
        end
        pop = 1'b0;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %b want 1", empty); end
        checks++; if (level !== 3'd0) begin errors++; $display("FAIL b2b_level_end: got %0d want 0", level); end
    endtask

    task automatic test_underflow();
        pop = 1'b1;
        step();
        checks++; if (level !== 3'd0)       begin errors++; $display("FAIL udf_level: got %0d want 0", level); end
        checks++; if (empty !== 1'b1)       begin errors++; $display("FAIL udf_empty: got %b want 1", empty); end
        checks++; if (underflow !== ERR_EN) begin errors++; $display("FAIL udf_set: got %b want %b", underflow, ERR_EN); end
        clr_err = 1'b1;
        step();
        checks++; if (underflow !== ERR_EN) begin errors++; $display("FAIL udf_set_prio: got %b want %b", underflow, ERR_EN); end
        pop = 1'b0;
        step();
        clr_err = 1'b0;
        checks++; if (underflow !== 1'b0)   begin errors++; $display("FAIL udf_clr: got %b want 0", underflow); end
        checks++; if (level !== 3'd0)       begin errors++; $display("FAIL udf_level_end: got %0d want 0", level); end
    endtask

    task automatic test_flush();
        for (int i = 1; i <= 3; i++) begin
            push = 1'b1; data_in = 8'(i);
            step();
        end
        checks++; if (level !== 3'd3)   begin errors++; $display("FAIL flush_pre_level: got %0d want 3", level); end
        checks++; if (data_out !== 8'h01) begin errors++; $display("FAIL flush_pre_head: got %h want 01", data_out); end
        flush = 1'b1; data_in = 8'h99;
        step();
        flush = 1'b0; push = 1'b0;
        checks++; if (level !== 3'd0)        begin errors++; $display("FAIL flush_level: got %0d want 0", level); end
        checks++; if (empty !== 1'b1)        begin errors++; $display("FAIL flush_empty: got %b want 1", empty); end
        checks++; if (ack !== 1'b0)          begin errors++; $display("FAIL flush_ack: got %b want 0", ack); end
        checks++; if (almost_empty !== 1'b1) begin errors++; $display("FAIL flush_aempty: got %b want 1", almost_empty); end
        push = 1'b1; data_in = 8'h5A;
        step();
        checks++; if (level !== 3'd1)     begin errors++; $display("FAIL flush_post_level: got %0d want 1", level); end
        checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL flush_post_head: got %h want 5a", data_out); end
        checks++; if (ack !== 1'b1)       begin errors++; $display("FAIL flush_post_ack: got %b want 1", ack); end
    endtask

    task automatic test_reset_mid();
        data_in = 8'h6B;
        step();
        push = 1'b0;
        checks++; if (level !== 3'd2) begin errors++; $display("FAIL rmid_pre_level: got %0d want 2", level); end
        checks++; if (ack !== 1'b1)   begin errors++; $display("FAIL rmid_pre_ack: got %b want 1", ack); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (empty !== 1'b1)     begin errors++; $display("FAIL rmid_empty: got %b want 1", empty); end
        checks++; if (level !== 3'd0)     begin errors++; $display("FAIL rmid_level: got %0d want 0", level); end
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rmid_data: got %h want 00", data_out); end
        checks++; if (ack !== 1'b0)       begin errors++; $display("FAIL rmid_ack: got %b want 0", ack); end
        reset_n = 1'b1;
        step();
        push = 1'b1; data_in = 8'h77;
        step();
        push = 1'b0;
        checks++; if (level !== 3'd1)     begin errors++; $display("FAIL rmid_post_level: got %0d want 1", level); end
        checks++; if (data_out !== 8'h77) begin errors++; $display("FAIL rmid_post_head: got %h want 77", data_out); end
        checks++; if (ack !== 1'b1)       begin errors++; $display("FAIL rmid_post_ack: got %b want 1", ack); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_fill();
        test_full_push_pop();
        test_back_to_back();
        test_underflow();
        test_flush();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_lvl.md
FIFO_LVL -- requirements
Module: fifo_lvl

Interface
REQ-001 SHALL provide parameter FIFO_WIDTH, default 8, data bits per entry.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, entry count; power of two, >= 2.
REQ-003 SHALL provide parameter AFULL_THRESH, default FIFO_DEPTH-1, level at or above which almost_full asserts.
REQ-004 SHALL provide parameter AEMPTY_THRESH, default 1, level at or below which almost_empty asserts.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port push  input  1  write request.
REQ-008 SHALL have port data_in  input  FIFO_WIDTH  write data.
REQ-009 SHALL have port pop  input  1  read request.
REQ-010 SHALL have port flush  input  1  synchronous clear of contents.
REQ-011 SHALL have port clr_err  input  1  clears sticky error flags.
REQ-012 SHALL have port ack  output  1  one-cycle pulse per accepted push.
REQ-013 SHALL have port data_out  output  FIFO_WIDTH  head entry, first-word fall-through.
REQ-014 SHALL have port full / empty  output  1 each  occupancy flags.
REQ-015 SHALL have port almost_full / almost_empty  output  1 each  threshold flags.
REQ-016 SHALL have port level  output  $clog2(FIFO_DEPTH)+1  current entry count, 0..FIFO_DEPTH.
REQ-017 SHALL have port overflow / underflow  output  1 each  sticky error flags.

Function
REQ-018 Push SHALL be accepted iff push && !full && !flush; data_in written at write pointer, write pointer +1.
REQ-019 Push while full SHALL be dropped: no write, no pointer change, no ack, even if pop asserted same cycle.
REQ-020 Pop SHALL be accepted iff pop && !empty && !flush; read pointer +1; pop while empty ignored.
REQ-021 ack SHALL be registered: high exactly one cycle after each accepted push, low otherwise.
REQ-022 data_out SHALL combinationally reflect entry at read pointer; valid when !empty, zero-latency after write edge.
REQ-023 Pointers SHALL be $clog2(FIFO_DEPTH)+1 bits, wrap modulo 2*FIFO_DEPTH; empty = all bits equal; full = low bits equal, MSB differs.
REQ-024 level SHALL equal write pointer minus read pointer modulo 2*FIFO_DEPTH, updated same edge as pointers.
REQ-025 Simultaneous accepted push and pop SHALL leave level unchanged; push+pop on empty accepts push only (level 0->1).
REQ-026 almost_full = (level >= AFULL_THRESH); almost_empty = (level <= AEMPTY_THRESH); both combinational from level.
REQ-027 flush SHALL zero both pointers next edge, override push/pop that cycle, suppress ack; storage contents untouched.

Reset
REQ-028 On reset_n low SHALL asynchronously clear pointers, ack, overflow, underflow, all storage entries to 0.
REQ-029 Reset outputs: empty=1, full=0, level=0, almost_empty=1, almost_full=(AFULL_THRESH==0), data_out=0, ack=0.
REQ-030 Reset asserted mid-operation SHALL discard all contents; first edge after release behaves as from empty.

Configuration
REQ-031 With macro FIFO_LVL_ERR_FLAGS_EN defined: overflow sets on push && full && !flush; underflow sets on pop && empty && !flush; both hold until clr_err.
REQ-032 With FIFO_LVL_ERR_FLAGS_EN defined: set SHALL take priority over clr_err in the same cycle.
REQ-033 Without FIFO_LVL_ERR_FLAGS_EN: overflow and underflow ports SHALL remain, tied to 0; clr_err ignored; no flag logic.

Verification (FIFO_WIDTH=8, FIFO_DEPTH=4, defaults)
REQ-034 Push 0x11,0x22,0x33,0x44 back-to-back -> ack each next cycle, level 1..4, full=1 after 4th, almost_full at level 3, data_out=0x11.
REQ-035 Full, push 0x55 with pop -> pop accepted, push dropped, no ack, level 3, data_out=0x22; overflow=1 if macro defined.
REQ-036 Level 2, push 0xAA with pop each cycle for 10 cycles -> level stays 2, pointers wrap, popped order matches pushed order.
REQ-037 Empty, pop -> no pointer change, level 0; underflow=1 if macro defined; then pop+clr_err same cycle -> underflow stays 1.
REQ-038 Level 3, flush with push -> next cycle level 0, empty=1, ack=0, almost_empty=1.
REQ-039 Level 2, reset_n low mid-cycle -> outputs immediately empty=1, level=0, data_out=0, ack=0 before next edge.
